// File: rtl/doorbell_pkg.sv
// Shared definitions for the doorbell chime sequencer: state encoding and default tick counts.
package doorbell_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DING = 2'd1,
        DONG = 2'd2,
        HOLD = 2'd3
    } state_e;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_DING_TICKS = 4;
    localparam int DEF_DONG_TICKS = 6;
    localparam int DEF_HOLD_TICKS = 2;

    // A phase of N ticks loads N-1, so N must lie in 1..2^cnt_w.
    function automatic bit ticks_ok(input int ticks, input int cnt_w);
        return (ticks >= 1) && (ticks <= (1 << cnt_w));
    endfunction

endpackage

// File: rtl/button_edge.sv
// Registered rising-edge detector for the push-button level. The history register
// resets high so a button held through reset release is not seen as a press.
module button_edge (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press
);

    logic button_q;
    logic press_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            button_q <= 1'b1;
            press_q  <= 1'b0;
        end else begin
            button_q <= button;
            press_q  <= button & ~button_q;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/doorbell_sequencer.sv
// Two-tone chime sequencer: drives the chime mux select through DING, DONG and a
// silent hold-off, each lasting a programmable number of time-base ticks.
module doorbell_sequencer
    import doorbell_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int DING_TICKS = DEF_DING_TICKS,
    parameter int DONG_TICKS = DEF_DONG_TICKS,
    parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    input  logic tick,
    output logic sel,
    output logic play,
    output logic busy,
    output logic done
);

    if (!ticks_ok(DING_TICKS, CNT_W) || !ticks_ok(DONG_TICKS, CNT_W) ||
        !ticks_ok(HOLD_TICKS, CNT_W)) begin : g_bad_ticks
        $error("doorbell_sequencer: tick counts must be in 1..2**CNT_W");
    end

    localparam logic [CNT_W-1:0] DING_LD = CNT_W'(DING_TICKS - 1);
    localparam logic [CNT_W-1:0] DONG_LD = CNT_W'(DONG_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_TICKS - 1);

    logic             press;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_d;
    logic             sel_q, play_q, busy_q, done_q;

    button_edge u_button_edge (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .press  (press)
    );

    // Presses outside IDLE fall through the default hold and are dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = DING;
                    cnt_d   = DING_LD;
                end
            end
            DING: begin
                if (tick) begin
                    if (cnt_q == '0) begin
                        state_d = DONG;
                        cnt_d   = DONG_LD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            DONG: begin
                if (tick) begin
                    if (cnt_q == '0) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LD;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode the next state so they change on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q  <= 1'b0;
            play_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sel_q  <= (state_d == DONG);
            play_q <= (state_d == DING) || (state_d == DONG);
            busy_q <= (state_d != IDLE);
            done_q <= done_d;
        end
    end

    assign sel  = sel_q;
    assign play = play_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_doorbell_sequencer.sv
// Directed bench for doorbell_sequencer: default-parameter instance plus a 1/1/1 corner instance.
module tb_doorbell_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic button = 1'b0;
    logic tick = 1'b0;
    logic sel, play, busy, done;
    logic sel1, play1, busy1, done1;

    always #5 clk = ~clk;

    doorbell_sequencer dut (
        .clk(clk), .rst(rst), .button(button), .tick(tick),
        .sel(sel), .play(play), .busy(busy), .done(done)
    );

    doorbell_sequencer #(
        .CNT_W(8), .DING_TICKS(1), .DONG_TICKS(1), .HOLD_TICKS(1)
    ) dut1 (
        .clk(clk), .rst(rst), .button(button), .tick(tick),
        .sel(sel1), .play(play1), .busy(busy1), .done(done1)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_ding, n_dong, n_busy, n_done, sel_bad, done_at, last_dong;
    int n1_ding, n1_dong, n1_busy, n1_done;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        n_ding = 0; n_dong = 0; n_busy = 0; n_done = 0; sel_bad = 0;
        done_at = -1; last_dong = -1;
        n1_ding = 0; n1_dong = 0; n1_busy = 0; n1_done = 0;
    endtask

    // Drive one cycle of inputs, cross the edge, then tally the new cycle's outputs.
    task automatic step(input logic b, input logic t);
        logic prev_sel;
        prev_sel = sel;
        button = b;
        tick   = t;
        @(posedge clk);
        #1;
        cyc++;
        if (play && !sel) n_ding++;
        if (play && sel) n_dong++;
        if (busy) n_busy++;
        if (done) begin n_done++; done_at = cyc; end
        if (sel) last_dong = cyc;
        if ((sel != prev_sel) && !t) sel_bad++;
        if (play1 && !sel1) n1_ding++;
        if (play1 && sel1) n1_dong++;
        if (busy1) n1_busy++;
        if (done1) n1_done++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr();
        // Reset with button held high, then release with it still held.
        rst = 1'b1; button = 1'b1; tick = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sel", sel, 0);
        chk("rst_play", play, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        clr();
        repeat (20) step(1'b1, 1'b1);
        chk("rst_hold_busy", n_busy, 0);
        chk("rst_hold_play", n_ding + n_dong, 0);
        chk("rst_hold_done", n_done, 0);
        chk("rst_hold_busy1", n1_busy, 0);

        // Basic chime with tick tied high; corner instance runs alongside.
        step(1'b0, 1'b1); step(1'b0, 1'b1);
        clr();
        step(1'b1, 1'b1);
        chk("lat_play_k", play, 0);
        step(1'b1, 1'b1);
        chk("lat_play_k1", play, 1);
        chk("lat_busy_k1", busy, 1);
        chk("lat_sel_k1", sel, 0);
        repeat (20) step(1'b1, 1'b1);
        chk("basic_ding", n_ding, 4);
        chk("basic_dong", n_dong, 6);
        chk("basic_busy", n_busy, 12);
        chk("basic_done", n_done, 1);
        chk("basic_done_pos", done_at, last_dong + 1);
        chk("corner_ding", n1_ding, 1);
        chk("corner_dong", n1_dong, 1);
        chk("corner_busy", n1_busy, 3);
        chk("corner_done", n1_done, 1);

        // Tick every third cycle, phased so the first tick lands in DING's third cycle.
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        clr();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int c = 0; c < 45; c++) step(1'b1, (c % 3) == 2);
        chk("slow_ding", n_ding, 12);
        chk("slow_dong", n_dong, 18);
        chk("slow_busy", n_busy, 36);
        chk("slow_done", n_done, 1);
        chk("slow_sel_no_tick", sel_bad, 0);

        // Re-presses in DING, in DONG and on the HOLD-expiry cycle are all dropped.
        step(1'b0, 1'b1); step(1'b0, 1'b1);
        clr();
        for (int j = 0; j < 30; j++)
            step((j == 0) || (j == 3) || (j == 8) || (j >= 12), 1'b1);
        chk("repress_ding", n_ding, 4);
        chk("repress_dong", n_dong, 6);
        chk("repress_busy", n_busy, 12);
        chk("repress_done", n_done, 1);

        // A press landing on the first IDLE cycle starts a second chime.
        step(1'b0, 1'b1); step(1'b0, 1'b1);
        clr();
        for (int j = 0; j < 30; j++)
            step((j == 0) || (j >= 13), 1'b1);
        chk("idle_press_ding", n_ding, 8);
        chk("idle_press_busy", n_busy, 24);
        chk("idle_press_done", n_done, 2);

        // Reset asserted mid-DONG, away from any clock edge.
        step(1'b0, 1'b1); step(1'b0, 1'b1);
        clr();
        step(1'b1, 1'b1);
        for (int i = 0; i < 20 && !sel; i++) step(1'b1, 1'b1);
        chk("mid_in_dong", sel, 1);
        step(1'b1, 1'b1);
        clr();
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_play", play, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        step(1'b1, 1'b1); step(1'b1, 1'b1);
        rst = 1'b0;
        repeat (20) step(1'b1, 1'b1);
        chk("mid_rst_no_done", n_done, 0);
        chk("mid_rst_no_busy", n_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
